// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// memory-busy freeze with save/restore of the in-progress stall.
module hazard_ctrl #(
  parameter int unsigned LU_STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_MemRead,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        ex_mem_hold,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles,
  output logic [7:0]  flush_count
);

  localparam int unsigned REM_W   = 2;
  localparam int unsigned STALL_W = 16;
  localparam int unsigned FLUSH_W = 8;

  generate
    if (LU_STALL_CYCLES < 1 || LU_STALL_CYCLES > 3) begin : g_bad_stall_len
      $error("hazard_ctrl: LU_STALL_CYCLES must be in 1..3");
    end
  endgenerate

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    FREEZE   = 2'b10
  } state_t;

  state_t             state_q, state_d, saved_q, saved_d, eff_state;
  logic [REM_W-1:0]   rem_q, rem_d, saved_rem_q, saved_rem_d, eff_rem;
  logic               lu;
  logic               flush_inc;

  assign state = state_q;

  assign lu = ex_MemRead && (ex_rt != 5'd0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // On FREEZE exit the cycle behaves as the state that was frozen.
  always_comb begin
    eff_state = state_q;
    eff_rem   = rem_q;
    if (state_q == FREEZE) begin
      eff_state = saved_q;
      eff_rem   = saved_rem_q;
    end
  end

  // Next-state and pipeline control outputs, in priority order.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_hold  = 1'b0;
    state_d      = state_q;
    rem_d        = rem_q;
    saved_d      = saved_q;
    saved_rem_d  = saved_rem_q;
    flush_inc    = 1'b0;

    if (!reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (mem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      ex_mem_hold = 1'b1;
      state_d     = FREEZE;
      if (state_q != FREEZE) begin
        saved_d     = state_q;
        saved_rem_d = rem_q;
      end
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_d      = RUN;
      rem_d        = '0;
      flush_inc    = 1'b1;
    end else if (eff_state == LU_STALL) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if (eff_rem <= REM_W'(1)) begin
        state_d = RUN;
        rem_d   = '0;
      end else begin
        state_d = LU_STALL;
        rem_d   = eff_rem - REM_W'(1);
      end
    end else if (lu) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      rem_d        = REM_W'(LU_STALL_CYCLES - 1);
      state_d      = (LU_STALL_CYCLES > 1) ? LU_STALL : RUN;
    end else begin
      state_d = RUN;
      rem_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= RUN;
      rem_q        <= '0;
      saved_q      <= RUN;
      saved_rem_q  <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      saved_q     <= saved_d;
      saved_rem_q <= saved_rem_d;
      if (!pc_write && (stall_cycles != {STALL_W{1'b1}}))
        stall_cycles <= stall_cycles + STALL_W'(1);
      if (flush_inc && (flush_count != {FLUSH_W{1'b1}}))
        flush_count <= flush_count + FLUSH_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1- and 3-cycle load-use stall) driven
// in lockstep, checked against a stall-debt reference model.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_MemRead, ex_branch_taken, mem_busy;

  logic        pc_write [2];
  logic        if_id_write [2];
  logic        if_id_flush [2];
  logic        id_ex_bubble [2];
  logic        ex_mem_hold [2];
  logic [1:0]  st [2];
  logic [15:0] sc [2];
  logic [7:0]  fc [2];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: outstanding stall cycles owed per instance.
  int lu_n [2] = '{1, 3};
  int m_owed [2];
  int m_state [2];
  int m_stalls [2];
  int m_flush [2];

  hazard_ctrl #(.LU_STALL_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .pc_write(pc_write[0]), .if_id_write(if_id_write[0]),
    .if_id_flush(if_id_flush[0]), .id_ex_bubble(id_ex_bubble[0]),
    .ex_mem_hold(ex_mem_hold[0]), .state(st[0]), .stall_cycles(sc[0]),
    .flush_count(fc[0])
  );

  hazard_ctrl #(.LU_STALL_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .pc_write(pc_write[1]), .if_id_write(if_id_write[1]),
    .if_id_flush(if_id_flush[1]), .id_ex_bubble(id_ex_bubble[1]),
    .ex_mem_hold(ex_mem_hold[1]), .state(st[1]), .stall_cycles(sc[1]),
    .flush_count(fc[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Compare registered values, then this cycle's outputs, then advance the model.
  task automatic step();
    logic       lu;
    logic [4:0] exp_o, got_o;
    lu = ex_MemRead && (ex_rt != 5'd0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    for (int k = 0; k < 2; k++) begin
      check($sformatf("state_n%0d", lu_n[k]), 32'(st[k]), 32'(m_state[k]));
      check($sformatf("stall_cycles_n%0d", lu_n[k]), 32'(sc[k]), 32'(m_stalls[k]));
      check($sformatf("flush_count_n%0d", lu_n[k]), 32'(fc[k]), 32'(m_flush[k]));
      if (!reset) begin
        exp_o = 5'b00110;
        m_owed[k] = 0; m_state[k] = 0; m_stalls[k] = 0; m_flush[k] = 0;
      end else if (mem_busy) begin
        exp_o = 5'b00001;
        m_state[k] = 2;
      end else if (ex_branch_taken) begin
        exp_o = 5'b11110;
        m_owed[k] = 0; m_state[k] = 0;
        if (m_flush[k] < 255) m_flush[k]++;
      end else if (m_owed[k] > 0) begin
        exp_o = 5'b00010;
        m_owed[k]--;
        m_state[k] = (m_owed[k] > 0) ? 1 : 0;
      end else if (lu) begin
        exp_o = 5'b00010;
        m_owed[k] = lu_n[k] - 1;
        m_state[k] = (m_owed[k] > 0) ? 1 : 0;
      end else begin
        exp_o = 5'b11000;
        m_state[k] = 0;
      end
      if (reset && !exp_o[4] && m_stalls[k] < 65535) m_stalls[k]++;
      got_o = {pc_write[k], if_id_write[k], if_id_flush[k], id_ex_bubble[k], ex_mem_hold[k]};
      check($sformatf("ctrl_outs_n%0d", lu_n[k]), 32'(got_o), 32'(exp_o));
    end
  endtask

  task automatic cyc(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urt, input logic mr, input logic [4:0] ert,
                     input logic br, input logic busy);
    @(negedge clk);
    reset = rst; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    ex_MemRead = mr; ex_rt = ert; ex_branch_taken = br; mem_busy = busy;
    #1;
    step();
  endtask

  task automatic idle();      cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); endtask
  task automatic do_rst();    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); endtask
  task automatic lu_hit();    cyc(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0); endtask
  task automatic busy_cyc();  cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1); endtask
  task automatic branch();    cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0); endtask
  task automatic settle();    @(posedge clk); #1; endtask

  initial begin
    reset = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    ex_MemRead = 1'b0; ex_rt = '0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_owed[k] = 0; m_state[k] = 0; m_stalls[k] = 0; m_flush[k] = 0;
    end
    repeat (2) @(posedge clk);

    // Single load-use hazard, EX bubbled afterwards.
    do_rst(); idle(); lu_hit(); idle(); idle(); idle(); settle();
    check("lu_total_n1", 32'(sc[0]), 32'd1);
    check("lu_total_n3", 32'(sc[1]), 32'd3);

    // ex_rt==0 and rt match without id_uses_rt never stall.
    do_rst();
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    cyc(1'b1, 5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    cyc(1'b1, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
    idle(); idle(); idle(); settle();
    check("no_stall_rt0_n3", 32'(sc[1]), 32'd3);

    // Taken branch during the second stall cycle cancels the stall.
    do_rst(); lu_hit(); branch(); settle();
    check("branch_flush_n3", 32'(fc[1]), 32'd1);
    check("branch_state_n3", 32'(st[1]), 32'd0);
    check("branch_stalls_n3", 32'(sc[1]), 32'd1);
    idle();

    // Freeze in the middle of a stall, then finish the owed cycle.
    do_rst(); lu_hit(); idle();
    repeat (4) busy_cyc();
    idle(); idle(); settle();
    check("freeze_stalls_n3", 32'(sc[1]), 32'd7);
    check("freeze_stalls_n1", 32'(sc[0]), 32'd5);
    check("freeze_state_n3", 32'(st[1]), 32'd0);
    idle();

    // Reset asserted during FREEZE abandons everything.
    do_rst(); lu_hit(); busy_cyc(); busy_cyc();
    cyc(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);
    settle();
    check("rst_freeze_state_n3", 32'(st[1]), 32'd0);
    check("rst_freeze_stalls_n3", 32'(sc[1]), 32'd0);
    idle(); idle();

    // flush_count saturation.
    do_rst();
    repeat (260) branch();
    settle();
    check("flush_sat_n1", 32'(fc[0]), 32'd255);
    check("flush_sat_n3", 32'(fc[1]), 32'd255);

    // Randomized traffic over a small register space so hazards are frequent.
    do_rst();
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 39) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
          ($urandom_range(0, 6) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
